// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment scanner with blanking, dp,
// leading-zero suppression, frame-coherent update and anti-ghosting dead time.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    if (DIGITS < 1 || DIGITS > 8 || CLK_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= CLK_DIV) begin : g_param_check
        $error("seg7_scan_driver: unsupported parameter combination");
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_pdata, r_adata;
    logic [DIGITS-1:0]   r_pdp, r_adp, r_pblank, r_ablank;
    logic                r_plz, r_alz;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_frame_done;

    logic                w_slot_end, w_wrap, w_sup, w_dp;
    logic [4*DIGITS-1:0] w_upper;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_dig;

    assign w_slot_end = r_cnt == CW'(CLK_DIV - 1);
    assign w_wrap     = w_slot_end && r_idx == IW'(DIGITS - 1);
    // Shifting the current digit down to bit 0 makes "this and all higher nibbles zero" a single test.
    assign w_upper    = r_adata >> {r_idx, 2'b00};
    assign w_sup      = r_alz && r_idx != '0 && w_upper == '0;
    assign w_seg      = (r_ablank[r_idx] || w_sup) ? 7'h00 : glyph(w_upper[3:0]);
    assign w_dp       = !r_ablank[r_idx] && r_adp[r_idx];
    assign w_dig      = (r_cnt >= CW'(BLANK_CYC)) ? DIGITS'(1) << r_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pdata      <= '0;
            r_pdp        <= '0;
            r_pblank     <= '0;
            r_plz        <= 1'b0;
            r_adata      <= '0;
            r_adp        <= '0;
            r_ablank     <= '0;
            r_alz        <= 1'b0;
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_dig        <= DIG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end)
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            if (load)
                {r_pdata, r_pdp, r_pblank, r_plz} <= {data_in, dp_in, blank_in, lz_en};
            if (w_wrap)
                {r_adata, r_adp, r_ablank, r_alz} <= load ? {data_in, dp_in, blank_in, lz_en}
                                                          : {r_pdata, r_pdp, r_pblank, r_plz};
            r_seg        <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
            r_dp         <= (SEG_ACTIVE_LOW != 0) ? ~w_dp : w_dp;
            r_dig        <= (DIG_ACTIVE_LOW != 0) ? ~w_dig : w_dig;
            r_frame_done <= w_wrap;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign dig_out    = r_dig;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench, DIGITS=4 CLK_DIV=8 BLANK_CYC=2, active-low segments and digits.
// Edge n after reset release samples cnt=(n-1)%8, idx=((n-1)/8)%4; frame f spans edges 32f+1..32f+32.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in, blank_in, dig_out;
    logic        lz_en, load, dp_out, frame_done;
    logic [6:0]  seg_out;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    seg7_scan_driver #(
        .DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_en(lz_en), .load(load), .seg_out(seg_out), .dp_out(dp_out),
        .dig_out(dig_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_load(input int n, input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        go(n - 1);
        data_in = d; dp_in = dp; blank_in = bl; lz_en = lz; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", seg_out, 7'h7F);
        chk("rst_dig", dig_out, 4'hF);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        cyc = 0;
        go(1);
        chk("f0_seg0", seg_out, 7'b1000000);
        chk("f0_dig_c0", dig_out, 4'hF);
        go(2);
        chk("f0_dig_c1", dig_out, 4'hF);
        go(3);
        chk("f0_dig_c2", dig_out, 4'hE);
        // frame 1 shows 1234 loaded during frame 0
        do_load(4, 16'h1234, 4'h0, 4'h0, 1'b0);
        go(9);
        chk("f0_seg1_old", seg_out, 7'b1000000);
        go(31);
        chk("fd_before_wrap", frame_done, 1'b0);
        go(32);
        chk("fd_wrap0", frame_done, 1'b1);
        go(33);
        chk("fd_after_wrap", frame_done, 1'b0);
        chk("f1_seg0", seg_out, 7'b0011001);
        chk("f1_dig0_blank", dig_out, 4'hF);
        chk("f1_dp0", dp_out, 1'b1);
        go(34);
        chk("f1_dig0_c1", dig_out, 4'hF);
        go(35);
        chk("f1_dig0_on", dig_out, 4'hE);
        go(41);
        chk("f1_seg1", seg_out, 7'b0110000);
        chk("f1_dig1_blank", dig_out, 4'hF);
        go(43);
        chk("f1_dig1_on", dig_out, 4'hD);
        go(49);
        chk("f1_seg2", seg_out, 7'b0100100);
        go(51);
        chk("f1_dig2_on", dig_out, 4'hB);
        go(57);
        chk("f1_seg3", seg_out, 7'b1111001);
        go(59);
        chk("f1_dig3_on", dig_out, 4'h7);
        go(63);
        chk("fd_mid", frame_done, 1'b0);
        go(64);
        chk("fd_wrap1", frame_done, 1'b1);
        // mid-frame load at idx=1 of frame 2 must not disturb frame 2
        do_load(76, 16'hABCD, 4'h0, 4'h0, 1'b0);
        go(81);
        chk("f2_seg2_old", seg_out, 7'b0100100);
        go(89);
        chk("f2_seg3_old", seg_out, 7'b1111001);
        go(97);
        chk("f3_seg0_D", seg_out, 7'b0100001);
        go(105);
        chk("f3_seg1_C", seg_out, 7'b1000110);
        go(113);
        chk("f3_seg2_b", seg_out, 7'b0000011);
        go(121);
        chk("f3_seg3_A", seg_out, 7'b0001000);
        // load on the exact wrap edge
        do_load(128, 16'h5678, 4'h0, 4'h0, 1'b0);
        chk("fd_wrap3", frame_done, 1'b1);
        go(129);
        chk("f4_seg0_8", seg_out, 7'b0000000);
        go(137);
        chk("f4_seg1_7", seg_out, 7'b1111000);
        // leading-zero suppression
        do_load(140, 16'h0050, 4'h0, 4'h0, 1'b1);
        go(161);
        chk("f5_lz_seg0", seg_out, 7'b1000000);
        go(169);
        chk("f5_lz_seg1", seg_out, 7'b0010010);
        do_load(170, 16'h0000, 4'h0, 4'h0, 1'b1);
        go(177);
        chk("f5_lz_seg2", seg_out, 7'h7F);
        go(179);
        chk("f5_lz_dig2", dig_out, 4'hB);
        go(185);
        chk("f5_lz_seg3", seg_out, 7'h7F);
        chk("f5_lz_dp3", dp_out, 1'b1);
        go(193);
        chk("f6_zero_seg0", seg_out, 7'b1000000);
        go(201);
        chk("f6_zero_seg1", seg_out, 7'h7F);
        do_load(202, 16'h0000, 4'h0, 4'h0, 1'b0);
        go(209);
        chk("f6_zero_seg2", seg_out, 7'h7F);
        go(217);
        chk("f6_zero_seg3", seg_out, 7'h7F);
        go(225);
        chk("f7_nolz_seg0", seg_out, 7'b1000000);
        go(233);
        chk("f7_nolz_seg1", seg_out, 7'b1000000);
        do_load(234, 16'h0050, 4'b0100, 4'h0, 1'b1);
        go(241);
        chk("f7_nolz_seg2", seg_out, 7'b1000000);
        go(249);
        chk("f7_nolz_seg3", seg_out, 7'b1000000);
        // decimal point on a suppressed digit, then blanking
        go(265);
        chk("f8_seg1", seg_out, 7'b0010010);
        chk("f8_dp1", dp_out, 1'b1);
        do_load(266, 16'h0050, 4'b0100, 4'b0100, 1'b1);
        go(273);
        chk("f8_seg2_dark", seg_out, 7'h7F);
        chk("f8_dp2_lit", dp_out, 1'b0);
        go(281);
        chk("f8_dp3", dp_out, 1'b1);
        go(297);
        chk("f9_seg1", seg_out, 7'b0010010);
        go(305);
        chk("f9_blank_seg2", seg_out, 7'h7F);
        chk("f9_blank_dp2", dp_out, 1'b1);
        // async reset with the counter at idx=2, cnt=5 of frame 10
        go(341);
        chk("f10_dig2_pre", dig_out, 4'hB);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg", seg_out, 7'h7F);
        chk("arst_dig", dig_out, 4'hF);
        chk("arst_dp", dp_out, 1'b1);
        chk("arst_fd", frame_done, 1'b0);
        tick();
        tick();
        chk("arst_hold_dig", dig_out, 4'hF);
        rst = 1'b0;
        cyc = 0;
        go(1);
        chk("rel_seg0", seg_out, 7'b1000000);
        chk("rel_dp0", dp_out, 1'b1);
        go(3);
        chk("rel_dig0", dig_out, 4'hE);
        go(9);
        chk("rel_seg1_cleared", seg_out, 7'b1000000);
        go(11);
        chk("rel_dig1", dig_out, 4'hD);
        go(31);
        chk("rel_fd_pre", frame_done, 1'b0);
        go(32);
        chk("rel_fd_wrap", frame_done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
